radix2_divider: RTL

Sequential signed 4-bit divider, the inverse operation of the Booth multiplier already in the lab datapath. Takes a two's-complement dividend and divisor, runs a fixed-latency restoring-division loop on magnitudes with a start/done handshake, and returns a truncated quotient and remainder plus divide-by-zero and overflow flags. Intended as the division unit next to the multiplier, with a control FSM driving a small shift/subtract datapath.

---
 rtl/radix2_divider_if.sv | 32 +++
 rtl/radix2_divider.sv | 134 +++++++++++++
 2 files changed

// File: rtl/radix2_divider_if.sv
// radix2_divider_if: start/done handshake, operand and result bundle for
// the signed 4-bit radix-2 divider.
//   start      requester -> divider  request, sampled only when the divider is ready
//   dividend   requester -> divider  signed 4-bit dividend, captured on accept
//   divisor    requester -> divider  signed 4-bit divisor, captured on accept
//   busy       divider -> requester  operation in progress
//   done       divider -> requester  one-cycle pulse, results valid
//   quotient   divider -> requester  signed quotient, truncated toward zero
//   remainder  divider -> requester  signed remainder, sign of dividend
//   dbz        divider -> requester  divide-by-zero flag of last operation
//   ovf        divider -> requester  overflow flag of last operation
interface radix2_divider_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  logic       ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/radix2_divider.sv
// radix2_divider: sequential signed 4-bit divider. Operands are converted
// to magnitudes, divided by a 4-iteration restoring shift/subtract loop,
// then signs are reapplied. Fixed latency: done pulses 5 cycles after the
// accepting edge; back-to-back throughput is one operation per 6 cycles.
//   clk   rising-edge clock
//   rst   asynchronous reset, active-low
//   bus   radix2_divider_if slave: start/operands in, busy/done/results out
module radix2_divider (
  input  logic             clk,
  input  logic             rst,
  radix2_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] a_q, a_d;          // partial remainder
  logic [3:0] q_q, q_d;          // quotient magnitude / shifted dividend
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] dvd_q, dvd_d;      // raw captured dividend
  logic [3:0] dvs_q, dvs_d;      // raw captured divisor
  logic       sgnq_q, sgnq_d;
  logic       sgnr_q, sgnr_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  logic [3:0] dvs_mag;
  logic [4:0] a_sh;
  logic [4:0] trial;

  // 4-bit magnitude; |-8| = 8 fits as unsigned 4'b1000
  function automatic logic [3:0] mag4(input logic [3:0] v);
    return v[3] ? (~v + 4'd1) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    dvs_mag = mag4(dvs_q);
    a_sh    = {a_q[3:0], q_q[3]};
    // a_sh <= 15 and dvs_mag <= 8, so bit 4 is a valid sign bit
    trial   = a_sh - {1'b0, dvs_mag};

    unique case (state_q)
      // DONE accepts a new start just like IDLE so that a start sampled on
      // the edge leaving DONE is taken, giving one operation per 6 cycles.
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          sgnq_d  = bus.dividend[3] ^ bus.divisor[3];
          sgnr_d  = bus.dividend[3];
          a_d     = '0;
          q_d     = mag4(bus.dividend);
          cnt_d   = 3'd4;
          state_d = ITER;
        end
      end
      ITER: begin
        a_d   = trial[4] ? a_sh : trial;
        q_d   = {q_q[2:0], ~trial[4]};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = FIX;
      end
      FIX: begin
        if (dvs_q == 4'd0) begin
          quot_d = '0;
          rem_d  = dvd_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = sgnq_q ? (~q_q + 4'd1) : q_q;
          rem_d  = sgnr_q ? (~a_q[3:0] + 4'd1) : a_q[3:0];
          dbz_d  = 1'b0;
          ovf_d  = (dvd_q == 4'b1000) && (dvs_q == 4'b1111);
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == ITER) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule
